// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: definitions shared by the pipeline controller and its users.
//   - stall vector bit indices (one bit per inter-stage register)
//   - the four stall vectors produced by stage stall requests
//   - exception codes seen on excepttype_i
//   - pipeline controller FSM states
package cpu_defs_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A stalled stage also freezes every stage upstream of it.
  localparam logic [5:0] STALL_VEC_MEM  = 6'b011111;
  localparam logic [5:0] STALL_VEC_EX   = 6'b001111;
  localparam logic [5:0] STALL_VEC_ID   = 6'b000111;
  localparam logic [5:0] STALL_VEC_IF   = 6'b000011;
  localparam logic [5:0] STALL_VEC_NONE = 6'b000000;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  // Later stages win: a downstream hold must freeze everything behind it.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] vec;
    vec = STALL_VEC_NONE;
    if (req_mem)     vec = STALL_VEC_MEM;
    else if (req_ex) vec = STALL_VEC_EX;
    else if (req_id) vec = STALL_VEC_ID;
    else if (req_if) vec = STALL_VEC_IF;
    return vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the core stages and the pipeline controller.
//   core -> ctrl : stallreq_from_{if,id,ex,mem}, excepttype_i, cp0_epc_i
//   ctrl -> core : stall[5:0], flush, new_pc, stall_timeout, stall_cycles
// modport master = core side, modport slave = controller side.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles and raises a sticky flag
// once STALL_TIMEOUT of them have elapsed.
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   stalled in  current cycle has a nonzero stall vector
//   timeout out sticky flag, cleared only by reset
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout
);

  localparam int unsigned CW = $clog2(STALL_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // Counter holds at CNT_MAX so a long stall cannot wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!stalled)              cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      if (stalled && cnt_q == CNT_MAX) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall / flush controller for the 5-stage pipeline.
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   bus  pipe_ctrl_if.slave: stage stall requests and MEM exception in,
//        stall vector, flush, redirect PC, watchdog flag, stall counter out
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal flow; stalls arbitrated, exceptions answered same cycle
// FLUSH | extra flush cycles, replaying the latched redirect target
module pipe_ctrl
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter int unsigned FLUSH_HOLD    = 1,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [0:0] S_RUN   = RUN;
  localparam logic [0:0] S_FLUSH = FLUSH;
  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

  logic [0:0]  state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] stall_cycles_q;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic [31:0] exc_target;
  logic        stalled;

  assign exc_target = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    redir_d  = redir_q;
    stall_c  = STALL_VEC_NONE;
    flush_c  = 1'b0;
    new_pc_c = 32'h0;
    case (state_q)
      S_RUN: begin
        if (bus.excepttype_i != EXC_NONE) begin
          flush_c  = 1'b1;
          new_pc_c = exc_target;
          redir_d  = exc_target;
          if (FLUSH_HOLD > 0) begin
            state_d = S_FLUSH;
            hold_d  = HOLD_INIT;
          end
        end else begin
          stall_c = stall_encode(bus.stallreq_from_if, bus.stallreq_from_id,
                                 bus.stallreq_from_ex, bus.stallreq_from_mem);
        end
      end
      S_FLUSH: begin
        // Inputs are ignored: anything arriving now belongs to a flushed instruction.
        flush_c  = 1'b1;
        new_pc_c = redir_q;
        hold_d   = hold_q - 1'b1;
        if (hold_q == 4'd1) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    // Keep outputs quiet while reset is held, even if an exception code is present.
    if (!rst) begin
      stall_c  = STALL_VEC_NONE;
      flush_c  = 1'b0;
      new_pc_c = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      hold_q  <= 4'd0;
      redir_q <= 32'h0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      redir_q <= redir_d;
    end
  end

  assign stalled = (stall_c != STALL_VEC_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     stall_cycles_q <= 32'h0;
    else if (stalled && stall_cycles_q != '1)     stall_cycles_q <= stall_cycles_q + 1'b1;
  end

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (stalled),
    .timeout (bus.stall_timeout)
  );

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.new_pc       = new_pc_c;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  typedef struct {
    int          dut;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        to;
    logic [31:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_vec = 0;
  int   n_err = 0;
  int unsigned exp_sc [2];
  exp_t sb_q [$];
  exp_t e;

  logic [5:0]  a_stall;
  logic        a_flush;
  logic [31:0] a_pc;
  logic        a_to;
  logic [31:0] a_sc;

  always #5 clk = ~clk;

  pipe_ctrl_if bus0 ();
  pipe_ctrl_if bus1 ();

  pipe_ctrl #(.FLUSH_HOLD(1), .STALL_TIMEOUT(8)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  pipe_ctrl #(.FLUSH_HOLD(3), .STALL_TIMEOUT(1024)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  // Push one cycle's expectation, then advance to just after the next rising edge.
  task automatic chk(input int d, input logic [5:0] s, input logic f,
                     input logic [31:0] pc, input logic to);
    exp_t x;
    x.dut    = d;
    x.stall  = s;
    x.flush  = f;
    x.new_pc = pc;
    x.to     = to;
    x.sc     = exp_sc[d];
    sb_q.push_back(x);
    if (s != 6'b0) exp_sc[d]++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        a_stall = bus0.stall; a_flush = bus0.flush; a_pc = bus0.new_pc;
        a_to = bus0.stall_timeout; a_sc = bus0.stall_cycles;
      end else begin
        a_stall = bus1.stall; a_flush = bus1.flush; a_pc = bus1.new_pc;
        a_to = bus1.stall_timeout; a_sc = bus1.stall_cycles;
      end
      n_vec++;
      if (a_stall !== e.stall || a_flush !== e.flush || a_pc !== e.new_pc ||
          a_to !== e.to || a_sc !== e.sc) begin
        n_err++;
        $display("FAIL vec%0d dut%0d: got stall=%b flush=%b new_pc=%h to=%b sc=%0d, want stall=%b flush=%b new_pc=%h to=%b sc=%0d",
                 n_vec, e.dut, a_stall, a_flush, a_pc, a_to, a_sc,
                 e.stall, e.flush, e.new_pc, e.to, e.sc);
      end
    end
  end

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    exp_sc[0] = 0;
    exp_sc[1] = 0;
    bus0.stallreq_from_if = 0; bus0.stallreq_from_id = 0;
    bus0.stallreq_from_ex = 0; bus0.stallreq_from_mem = 0;
    bus0.excepttype_i = 32'h0; bus0.cp0_epc_i = 32'h0;
    bus1.stallreq_from_if = 0; bus1.stallreq_from_id = 0;
    bus1.stallreq_from_ex = 0; bus1.stallreq_from_mem = 0;
    bus1.excepttype_i = 32'h0; bus1.cp0_epc_i = 32'h0;

    @(posedge clk);
    #1;
    // reset values, with a request pending that must not show through
    bus0.stallreq_from_mem = 1;
    chk(0, 6'b000000, 0, 32'h0, 0);
    bus0.stallreq_from_mem = 0;
    chk(1, 6'b000000, 0, 32'h0, 0);
    rst0 = 1'b1;
    rst1 = 1'b1;

    // load-use stall for three cycles
    bus0.stallreq_from_id = 1;
    repeat (3) chk(0, 6'b000111, 0, 32'h0, 0);
    bus0.stallreq_from_id = 0;
    chk(0, 6'b000000, 0, 32'h0, 0);

    // priority encoding
    bus0.stallreq_from_if = 1; bus0.stallreq_from_ex = 1; bus0.stallreq_from_mem = 1;
    chk(0, 6'b011111, 0, 32'h0, 0);
    bus0.stallreq_from_mem = 0;
    chk(0, 6'b001111, 0, 32'h0, 0);
    bus0.stallreq_from_ex = 0;
    chk(0, 6'b000011, 0, 32'h0, 0);
    bus0.stallreq_from_id = 1;
    chk(0, 6'b000111, 0, 32'h0, 0);
    bus0.stallreq_from_if = 0; bus0.stallreq_from_id = 0;
    chk(0, 6'b000000, 0, 32'h0, 0);

    // exception beats a MEM stall; flush lasts 2 cycles
    bus0.stallreq_from_mem = 1; bus0.excepttype_i = 32'h8;
    chk(0, 6'b000000, 1, 32'hBFC00380, 0);
    bus0.excepttype_i = 32'h0;
    chk(0, 6'b000000, 1, 32'hBFC00380, 0);
    chk(0, 6'b011111, 0, 32'h0, 0);
    bus0.stallreq_from_mem = 0;
    chk(0, 6'b000000, 0, 32'h0, 0);

    // ERET to EPC; second exception in hold cycle dropped
    bus0.excepttype_i = 32'hE; bus0.cp0_epc_i = 32'h80001234;
    chk(0, 6'b000000, 1, 32'h80001234, 0);
    bus0.excepttype_i = 32'hC; bus0.cp0_epc_i = 32'h0;
    chk(0, 6'b000000, 1, 32'h80001234, 0);
    bus0.excepttype_i = 32'h0;
    chk(0, 6'b000000, 0, 32'h0, 0);
    chk(0, 6'b000000, 0, 32'h0, 0);

    // watchdog with STALL_TIMEOUT = 8
    bus0.stallreq_from_mem = 1;
    for (int i = 0; i < 10; i++) chk(0, 6'b011111, 0, 32'h0, (i >= 8));
    bus0.stallreq_from_mem = 0;
    chk(0, 6'b000000, 0, 32'h0, 1);
    chk(0, 6'b000000, 0, 32'h0, 1);

    // FLUSH_HOLD = 3: four flush cycles
    bus1.excepttype_i = 32'h8;
    chk(1, 6'b000000, 1, 32'hBFC00380, 0);
    bus1.excepttype_i = 32'h0;
    repeat (3) chk(1, 6'b000000, 1, 32'hBFC00380, 0);
    chk(1, 6'b000000, 0, 32'h0, 0);

    // reset in the middle of a flush window
    bus1.excepttype_i = 32'hE; bus1.cp0_epc_i = 32'h80005678;
    chk(1, 6'b000000, 1, 32'h80005678, 0);
    bus1.excepttype_i = 32'h0;
    chk(1, 6'b000000, 1, 32'h80005678, 0);
    rst1 = 1'b0;
    exp_sc[1] = 0;
    chk(1, 6'b000000, 0, 32'h0, 0);
    rst1 = 1'b1;
    chk(1, 6'b000000, 0, 32'h0, 0);
    chk(1, 6'b000000, 0, 32'h0, 0);
    bus1.stallreq_from_ex = 1;
    chk(1, 6'b001111, 0, 32'h0, 0);
    bus1.stallreq_from_ex = 0;
    chk(1, 6'b000000, 0, 32'h0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core; drives the `stall[5:0]` vector and `flush` consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates stall requests from IF/ID/EX/MEM and sequences exception and ERET redirection from the MEM stage, including a multi-cycle flush window.
- Also provides a stall-timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for any exception other than ERET.
- FLUSH_HOLD, 1, extra cycles flush stays high after the triggering cycle (range 0..15).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before `stall_timeout` sets (must be ≥ 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_from_if  in  1  IF stage needs to hold.
- stallreq_from_id  in  1  ID stage needs to hold (load-use).
- stallreq_from_ex  in  1  EX stage needs to hold (multi-cycle div/madd).
- stallreq_from_mem  in  1  MEM stage needs to hold (bus wait).
- excepttype_i  in  32  MEM-stage exception code; 0 means none; 32'h0000000E means ERET.
- cp0_epc_i  in  32  current EPC, already forwarded.
- stall  out  6  bit0 = pc, bit1 = if, bit2 = id, bit3 = ex, bit4 = mem, bit5 = wb.
- flush  out  1  clear all inter-stage registers.
- new_pc  out  32  redirect target; valid while `flush` = 1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  saturating count of cycles with `stall` ≠ 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = RUN, hold counter = 0, watchdog counter = 0.
  - `stall` = 0, `flush` = 0, `new_pc` = 0, `stall_timeout` = 0, `stall_cycles` = 0.
  - Reset mid-flush aborts the flush immediately.
- FSM states: RUN and FLUSH.
- RUN, `excepttype_i` ≠ 0 (same-cycle, combinational response):
  - `flush` = 1 and `stall` = 000000; the exception overrides all stall requests.
  - `new_pc` = `cp0_epc_i` if `excepttype_i` = 0xE, else EXC_VECTOR.
  - The target is latched into a redirect register.
  - If FLUSH_HOLD > 0: go to FLUSH with hold counter = FLUSH_HOLD. If FLUSH_HOLD = 0: stay in RUN.
- RUN, `excepttype_i` = 0: `flush` = 0; `new_pc` = 0; `stall` is priority-encoded, highest priority first:
  - mem → 011111
  - ex → 001111
  - id → 000111
  - if → 000011
  - none → 000000
- FLUSH:
  - `flush` = 1, `stall` = 0, `new_pc` = latched redirect register.
  - `excepttype_i` and all stall requests are ignored.
  - Hold counter decrements each cycle; on the cycle it reads 1, the next state is RUN.
  - Total flush width = 1 + FLUSH_HOLD cycles.
- Combinational paths: `stall`/`flush`/`new_pc` are combinational from state plus inputs in RUN, and from registers only in FLUSH. There is no path from `new_pc` back to any input.
- Watchdog:
  - Counter increments every cycle `stall` ≠ 0 and clears on any cycle `stall` = 0, including flush cycles.
  - When the counter reaches STALL_TIMEOUT − 1 while stalled, `stall_timeout` sets on the next edge.
  - `stall_timeout` stays set until reset; the counter saturates at STALL_TIMEOUT − 1.
- Performance counter: `stall_cycles` increments on each edge where `stall` ≠ 0 and saturates at 32'hFFFFFFFF with no wrap.
- Simultaneous events:
  - Exception plus any stall request in RUN: exception wins, and that cycle is not counted as stalled.
  - Back-to-back exceptions: only the first is taken; any arriving during FLUSH is dropped, because its instruction is being flushed.

Decomposition:
- Shared package `cpu_defs_pkg` holds:
  - stall bit indices (STALL_PC … STALL_WB) and the four stall vector constants;
  - EXC_ERET = 32'h0000000E, EXC_NONE = 0;
  - the FSM state enum {RUN, FLUSH}.
- One natural sub-module, `stall_watchdog`, containing the watchdog counter and sticky flag, parameterised by STALL_TIMEOUT.

Test Plan:
- Reset, then assert stallreq_from_id for 3 cycles → `stall` = 000111 for exactly those 3 cycles, `stall_cycles` = 3, `flush` = 0 throughout.
- Assert stallreq_from_if, stallreq_from_ex and stallreq_from_mem together → `stall` = 011111; drop mem only → `stall` = 001111 next cycle.
- `excepttype_i` = 0x8 with stallreq_from_mem = 1, FLUSH_HOLD = 1 → `flush` = 1 for 2 cycles, `stall` = 0, `new_pc` = 0xBFC00380 both cycles, `stall_cycles` unchanged.
- `excepttype_i` = 0xE with `cp0_epc_i` = 0x80001234; change EPC to 0 and pulse `excepttype_i` = 0xC in the hold cycle → `new_pc` = 0x80001234 for both flush cycles, second exception dropped, RUN afterwards.
- Hold stallreq_from_mem with STALL_TIMEOUT = 8 → `stall_timeout` rises after the 8th stalled cycle and stays high after the request drops.
- Drive rst low in the middle of a FLUSH_HOLD = 3 window → all outputs 0 asynchronously, state RUN; after release, no residual flush.
